order_size_engine: RTL and testbench

Pipelined, parametrised successor to the single-value order-quantity calculator: converts signed inventory and a runtime shape parameter into a bid size and an ask size via Guéant-style exponential skew. Each side is `BASE_QTY` while inventory pushes away from it, and `BASE_QTY·exp(-|η·q|)` while inventory pushes toward it. The block sits between the inventory tracker and the quote generator, with a valid/ready stream on each side.

---
 rtl/order_size_engine.sv | 152 +++++++++++++++
 tb/tb_order_size_engine.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/order_size_engine.sv
// order_size_engine: four-stage valid/ready pipeline turning signed inventory and a
// Q0.32 shape parameter into bid/ask sizes with exponential skew on the reduced side.
module order_size_engine #(
  parameter int unsigned INV_W    = 64,
  parameter int unsigned QTY_W    = 32,
  parameter int unsigned BASE_QTY = 100,
  parameter int unsigned MIN_QTY  = 1,
  parameter int unsigned SEQ_W    = 16
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [INV_W-1:0] i_inventory,
  input  logic [31:0]      i_shape,
  input  logic             i_valid,
  output logic             o_ready,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [QTY_W-1:0] o_bid_qty,
  output logic [QTY_W-1:0] o_ask_qty,
  output logic             o_sat,
  output logic [SEQ_W-1:0] o_seq
);

  localparam int unsigned XW = INV_W + 33;

  // exp(-k/32) in Q.16, rounded. Built from exp(-1/32) in Q.62 (Taylor series with
  // x = 1/32) raised to the power k by square-and-multiply over the bits of k.
  function automatic logic [16:0] exp_entry(input int unsigned k);
    logic [63:0] term;
    logic [63:0] base;
    logic [63:0] p;
    term = 64'd1 << 62;
    base = term;
    for (int n = 1; n < 16; n++) begin
      term = (term >> 5) / 64'(n);
      if (n % 2 == 1) base = base - term;
      else            base = base + term;
    end
    p = 64'd1 << 62;
    for (int b = 0; b < 8; b++) begin
      if (k[b]) p = 64'((128'(p) * 128'(base)) >> 62);
      base = 64'((128'(base) * 128'(base)) >> 62);
    end
    return 17'((p + (64'd1 << 45)) >> 46);
  endfunction

  logic [16:0] rom [256];
  for (genvar k = 0; k < 256; k++) begin : g_rom
    localparam logic [16:0] ENTRY = exp_entry(k);
    assign rom[k] = ENTRY;
  end

  // Global stall: every stage moves together, only when the output slot frees up.
  logic en;
  assign en      = !o_valid || i_ready;
  assign o_ready = en;

  // S1: signed inventory times unsigned shape, Q.32 product.
  logic signed [XW-1:0] x_q;
  logic                 v1_q;
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      x_q  <= '0;
      v1_q <= 1'b0;
    end else if (en) begin
      v1_q <= i_valid;
      x_q  <= XW'($signed(i_inventory)) * XW'($signed({1'b0, i_shape}));
    end
  end

  // Magnitude bits from 1/32 upwards; wide enough that |most negative x| cannot wrap.
  logic [XW-28:0] m_hi;
  always_comb begin
    m_hi = (XW-27)'(((x_q < 0) ? -x_q : x_q) >> 27);
  end

  // S2: sign/zero flags, saturation (|x| >= 8.0) and ROM address.
  logic       neg2_q, zero2_q, sat2_q, v2_q;
  logic [7:0] addr2_q;
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      neg2_q  <= 1'b0;
      zero2_q <= 1'b0;
      sat2_q  <= 1'b0;
      addr2_q <= '0;
      v2_q    <= 1'b0;
    end else if (en) begin
      neg2_q  <= x_q < 0;
      zero2_q <= x_q == '0;
      sat2_q  <= |m_hi[XW-28:8];
      addr2_q <= m_hi[7:0];
      v2_q    <= v1_q;
    end
  end

  // S3: registered ROM read, forced to zero on saturation.
  logic [16:0] e3_q;
  logic        neg3_q, zero3_q, sat3_q, v3_q;
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      e3_q    <= '0;
      neg3_q  <= 1'b0;
      zero3_q <= 1'b0;
      sat3_q  <= 1'b0;
      v3_q    <= 1'b0;
    end else if (en) begin
      e3_q    <= sat2_q ? 17'd0 : rom[addr2_q];
      neg3_q  <= neg2_q;
      zero3_q <= zero2_q;
      sat3_q  <= sat2_q;
      v3_q    <= v2_q;
    end
  end

  // Reduced-side quantity: floor(BASE_QTY * e / 2^16), floored at MIN_QTY.
  logic [QTY_W-1:0] red_qty;
  always_comb begin
    red_qty = QTY_W'((64'(BASE_QTY) * 64'(e3_q)) >> 16);
    if (red_qty < QTY_W'(MIN_QTY)) red_qty = QTY_W'(MIN_QTY);
  end

  // S4: output register and result sequence counter; bubbles clear o_valid only.
  logic [SEQ_W-1:0] seq_q;
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_valid   <= 1'b0;
      o_bid_qty <= '0;
      o_ask_qty <= '0;
      o_sat     <= 1'b0;
      o_seq     <= '0;
      seq_q     <= '0;
    end else if (en) begin
      o_valid <= v3_q;
      if (v3_q) begin
        o_sat <= sat3_q && !zero3_q;
        o_seq <= seq_q;
        seq_q <= seq_q + SEQ_W'(1);
        if (zero3_q) begin
          o_bid_qty <= QTY_W'(BASE_QTY);
          o_ask_qty <= QTY_W'(BASE_QTY);
        end else if (!neg3_q) begin
          o_bid_qty <= red_qty;
          o_ask_qty <= QTY_W'(BASE_QTY);
        end else begin
          o_bid_qty <= QTY_W'(BASE_QTY);
          o_ask_qty <= red_qty;
        end
      end
    end
  end

endmodule

// File: tb/tb_order_size_engine.sv
// Directed bench for order_size_engine: hand-computed vectors, backpressure and reset.
module tb_order_size_engine;

  logic        i_clk;
  logic        i_reset;
  logic [63:0] i_inventory;
  logic [31:0] i_shape;
  logic        i_valid;
  logic        o_ready;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_bid_qty;
  logic [31:0] o_ask_qty;
  logic        o_sat;
  logic [15:0] o_seq;

  int checks = 0;
  int errors = 0;

  order_size_engine dut (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_inventory (i_inventory),
    .i_shape     (i_shape),
    .i_valid     (i_valid),
    .o_ready     (o_ready),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_bid_qty   (o_bid_qty),
    .o_ask_qty   (o_ask_qty),
    .o_sat       (o_sat),
    .o_seq       (o_seq)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Backpressure stream: x = q/256 with shape 2^-8.
  logic [63:0] bp_q   [8] = '{64'd0, -64'sd256, 64'd256, 64'd512, -64'sd512, 64'd8, -64'sd8,
                              64'd2048};
  int          bp_bid [8] = '{100, 100, 36, 13, 100, 96, 100, 1};
  int          bp_ask [8] = '{100, 36, 100, 100, 13, 100, 96, 100};
  bit          bp_sat [8] = '{0, 0, 0, 0, 0, 0, 0, 1};

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  // One transaction with an empty pipeline; also pins the 4-register latency.
  task automatic send_check(input string tag, input logic [63:0] q, input logic [31:0] eta,
                            input int eb, input int ea, input bit es, input int eseq);
    chk({tag, " ready"}, 64'(o_ready), 64'd1);
    i_valid     = 1'b1;
    i_inventory = q;
    i_shape     = eta;
    step();
    i_valid = 1'b0;
    step();
    step();
    chk({tag, " early"}, 64'(o_valid), 64'd0);
    step();
    chk({tag, " valid"}, 64'(o_valid), 64'd1);
    chk({tag, " bid"}, 64'(o_bid_qty), 64'(eb));
    chk({tag, " ask"}, 64'(o_ask_qty), 64'(ea));
    chk({tag, " sat"}, 64'(o_sat), 64'(es));
    chk({tag, " seq"}, 64'(o_seq), 64'(eseq));
    step();
  endtask

  initial begin
    int sent;
    int got;
    bit acc;
    bit stalled_prev;
    logic [31:0] snap_bid, snap_ask;
    logic [15:0] snap_seq;

    i_reset     = 1'b1;
    i_valid     = 1'b0;
    i_ready     = 1'b1;
    i_inventory = '0;
    i_shape     = '0;
    repeat (3) step();
    i_reset = 1'b0;
    #1;
    chk("rst valid", 64'(o_valid), 64'd0);
    chk("rst bid", 64'(o_bid_qty), 64'd0);
    chk("rst ask", 64'(o_ask_qty), 64'd0);
    chk("rst sat", 64'(o_sat), 64'd0);
    chk("rst seq", 64'(o_seq), 64'd0);
    chk("rst ready", 64'(o_ready), 64'd1);

    send_check("flat", 64'd0, 32'h0147_AE14, 100, 100, 1'b0, 0);
    send_check("short", -64'sd256, 32'h0100_0000, 100, 36, 1'b0, 1);
    send_check("long", 64'd200, 32'h0147_AE14, 37, 100, 1'b0, 2);
    send_check("sat long", 64'd10000, 32'h0147_AE14, 1, 100, 1'b1, 3);
    send_check("extreme", 64'h8000_0000_0000_0000, 32'hFFFF_FFFF, 100, 1, 1'b1, 4);
    send_check("entry0", 64'd1, 32'h0000_0001, 100, 100, 1'b0, 5);
    send_check("below8", 64'd8, 32'hFFFF_FFFF, 1, 100, 1'b0, 6);
    send_check("exact8", -64'sd16, 32'h8000_0000, 100, 1, 1'b1, 7);

    // Stream 8 inputs with i_ready held low for cycles 3..12.
    sent = 0;
    got = 0;
    stalled_prev = 1'b0;
    snap_bid = '0;
    snap_ask = '0;
    snap_seq = '0;
    for (int cyc = 0; cyc < 80 && got < 8; cyc++) begin
      i_ready     = !(cyc >= 3 && cyc < 13);
      i_valid     = sent < 8;
      i_inventory = bp_q[sent < 8 ? sent : 0];
      i_shape     = 32'h0100_0000;
      #1;
      if (stalled_prev) begin
        chk("bp hold bid", 64'(o_bid_qty), 64'(snap_bid));
        chk("bp hold ask", 64'(o_ask_qty), 64'(snap_ask));
        chk("bp hold seq", 64'(o_seq), 64'(snap_seq));
      end
      if (!i_ready && o_valid) begin
        chk("bp ready low", 64'(o_ready), 64'd0);
        snap_bid = o_bid_qty;
        snap_ask = o_ask_qty;
        snap_seq = o_seq;
        stalled_prev = 1'b1;
      end else begin
        stalled_prev = 1'b0;
      end
      if (o_valid && i_ready) begin
        chk("bp bid", 64'(o_bid_qty), 64'(bp_bid[got]));
        chk("bp ask", 64'(o_ask_qty), 64'(bp_ask[got]));
        chk("bp sat", 64'(o_sat), 64'(bp_sat[got]));
        chk("bp seq", 64'(o_seq), 64'(8 + got));
        got++;
      end
      acc = i_valid && o_ready;
      step();
      if (acc) sent++;
    end
    chk("bp count", 64'(got), 64'd8);
    i_valid = 1'b0;
    i_ready = 1'b1;
    step();
    chk("bp drained", 64'(o_valid), 64'd0);

    // Three results in flight, then a one-cycle reset.
    for (int i = 0; i < 3; i++) begin
      i_valid     = 1'b1;
      i_inventory = 64'(256 * (i + 1));
      i_shape     = 32'h0100_0000;
      step();
    end
    i_valid = 1'b0;
    i_reset = 1'b1;
    step();
    i_reset = 1'b0;
    #1;
    chk("mid rst valid", 64'(o_valid), 64'd0);
    chk("mid rst bid", 64'(o_bid_qty), 64'd0);
    chk("mid rst ask", 64'(o_ask_qty), 64'd0);
    chk("mid rst sat", 64'(o_sat), 64'd0);
    chk("mid rst seq", 64'(o_seq), 64'd0);
    chk("mid rst ready", 64'(o_ready), 64'd1);
    for (int i = 0; i < 6; i++) begin
      step();
      chk("no stale", 64'(o_valid), 64'd0);
    end
    send_check("post rst", 64'd256, 32'h0100_0000, 36, 100, 1'b0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
